// File: rtl/itch_frame_tx.sv
// itch_frame_tx: transmit-side ITCH framer.
// Emits a 2-byte big-endian length header followed by exactly the declared
// number of payload bytes. Short payloads are zero-padded, excess bytes are
// dropped, and illegal lengths are rejected without emitting anything.
module itch_frame_tx #(
    parameter int MAX_LEN = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        msg_valid,
    input  logic [15:0] msg_len,
    output logic        msg_ready,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        out_start,
    output logic [15:0] out_expected_len,
    output logic        frame_done,
    output logic        err_underrun,
    output logic        err_overrun,
    output logic        len_reject
);

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    // State names describe what the output register holds or produces next.
    // The header MSB is loaded on the descriptor handshake itself so that it
    // appears in the very next cycle.
    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        PAYLOAD,
        PAD,
        DRAIN
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] len, len_nxt;
    logic [15:0] count, count_nxt;
    logic [15:0] count_inc;
    logic [15:0] exp_len_nxt;
    logic [7:0]  data_nxt;
    logic        valid_nxt, last_nxt;
    logic        start_nxt, done_nxt, under_nxt, over_nxt, rej_nxt;
    logic        msg_ready_nxt;
    logic        out_free, msg_hs, in_hs, len_ok;

    // The output register can take a new byte when empty or when it drains this cycle.
    assign out_free  = !out_valid || out_ready;
    assign msg_hs    = msg_valid && msg_ready;
    assign in_hs     = in_valid && in_ready;
    assign count_inc = count + 16'd1;
    assign len_ok    = (msg_len != 16'd0) && (msg_len <= MAX_LEN_W);

    // Payload is accepted only when it can go straight into the output register;
    // HDR_LO is included so the first payload byte follows the header without a bubble.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            HDR_LO, PAYLOAD: in_ready = out_free;
            DRAIN:           in_ready = 1'b1;
            default:         in_ready = 1'b0;
        endcase
    end

    // Next-state, output-register and pulse logic.
    always_comb begin
        state_nxt   = state;
        len_nxt     = len;
        count_nxt   = count;
        exp_len_nxt = out_expected_len;
        data_nxt    = out_data;
        valid_nxt   = out_valid;
        last_nxt    = out_last;
        start_nxt   = 1'b0;
        under_nxt   = 1'b0;
        over_nxt    = 1'b0;
        rej_nxt     = 1'b0;
        done_nxt    = out_valid && out_ready && out_last;

        // A pending byte leaves on its handshake unless a new one replaces it below.
        if (out_valid && out_ready) begin
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
        end

        case (state)
            IDLE: begin
                if (msg_hs) begin
                    len_nxt   = msg_len;
                    count_nxt = 16'd0;
                    if (len_ok) begin
                        state_nxt   = HDR_HI;
                        start_nxt   = 1'b1;
                        exp_len_nxt = msg_len + 16'd2;
                        data_nxt    = msg_len[15:8];
                        valid_nxt   = 1'b1;
                        last_nxt    = 1'b0;
                    end else begin
                        rej_nxt   = 1'b1;
                        state_nxt = DRAIN;
                    end
                end
            end
            HDR_HI: begin
                if (out_free) begin
                    data_nxt  = len[7:0];
                    valid_nxt = 1'b1;
                    state_nxt = HDR_LO;
                end
            end
            HDR_LO, PAYLOAD: begin
                if (out_free) begin
                    state_nxt = PAYLOAD;
                end
                if (in_hs) begin
                    data_nxt  = in_data;
                    valid_nxt = 1'b1;
                    last_nxt  = 1'b0;
                    count_nxt = count_inc;
                    if (count_inc == len) begin
                        last_nxt = 1'b1;
                        if (in_last) begin
                            state_nxt = IDLE;
                        end else begin
                            over_nxt  = 1'b1;
                            state_nxt = DRAIN;
                        end
                    end else if (in_last) begin
                        under_nxt = 1'b1;
                        state_nxt = PAD;
                    end
                end
            end
            PAD: begin
                if (out_free) begin
                    data_nxt  = 8'h00;
                    valid_nxt = 1'b1;
                    count_nxt = count_inc;
                    last_nxt  = (count_inc == len);
                    if (count_inc == len) begin
                        state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (in_hs && in_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        msg_ready_nxt = (state_nxt == IDLE) && !valid_nxt;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Output register, bookkeeping and registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len              <= 16'd0;
            count            <= 16'd0;
            out_data         <= 8'h00;
            out_valid        <= 1'b0;
            out_last         <= 1'b0;
            out_start        <= 1'b0;
            out_expected_len <= 16'd0;
            frame_done       <= 1'b0;
            err_underrun     <= 1'b0;
            err_overrun      <= 1'b0;
            len_reject       <= 1'b0;
            msg_ready        <= 1'b0;
        end else begin
            len              <= len_nxt;
            count            <= count_nxt;
            out_data         <= data_nxt;
            out_valid        <= valid_nxt;
            out_last         <= last_nxt;
            out_start        <= start_nxt;
            out_expected_len <= exp_len_nxt;
            frame_done       <= done_nxt;
            err_underrun     <= under_nxt;
            err_overrun      <= over_nxt;
            len_reject       <= rej_nxt;
            msg_ready        <= msg_ready_nxt;
        end
    end

endmodule

// File: tb/tb_itch_frame_tx.sv
// Testbench for itch_frame_tx: table of message scenarios plus hand-written
// reset sequences.
module tb_itch_frame_tx;

    localparam int MAX_LEN = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        msg_valid;
    logic [15:0] msg_len;
    logic        msg_ready;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        out_start;
    logic [15:0] out_expected_len;
    logic        frame_done;
    logic        err_underrun;
    logic        err_overrun;
    logic        len_reject;

    always #5 clk = ~clk;

    itch_frame_tx #(.MAX_LEN(MAX_LEN)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .msg_valid        (msg_valid),
        .msg_len          (msg_len),
        .msg_ready        (msg_ready),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_last         (out_last),
        .out_ready        (out_ready),
        .out_start        (out_start),
        .out_expected_len (out_expected_len),
        .frame_done       (frame_done),
        .err_underrun     (err_underrun),
        .err_overrun      (err_overrun),
        .len_reject       (len_reject)
    );

    // Scenario record: payload bytes packed MSB-first, expected output bytes
    // likewise (bytes beyond the sixth are expected to be 0x00 padding).
    typedef struct {
        logic [15:0] len;
        int          nin;
        logic [31:0] din;
        int          nout;
        logic [47:0] dout;
        bit          bp;
        int          under;
        int          over;
        int          rej;
    } vec_t;

    vec_t vecs[8];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor state
    logic [7:0] obuf[$];
    int         last_idx, last_cnt;
    int         n_start, n_done, n_under, n_over, n_rej, n_in;
    logic [15:0] mon_explen;
    int         mon_cyc = 0;
    int         first_cyc, lastb_cyc;
    bit         prv_stall = 1'b0;
    logic [7:0] prv_data = 8'h00;
    logic       prv_last = 1'b0;
    bit         chk_inrdy = 1'b0;
    bit         bp = 1'b0;
    int         cyc = 0;

    // Sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        mon_cyc++;
        if (!rst_n) begin
            prv_stall = 1'b0;
        end else begin
            if (prv_stall) begin
                check("stall_data", 32'(out_data), 32'(prv_data));
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_last", 32'(out_last), 32'(prv_last));
            end
            if (chk_inrdy && out_valid && !out_ready)
                check("inrdy_stall", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (obuf.size() == 0) first_cyc = mon_cyc;
                lastb_cyc = mon_cyc;
                if (out_last) begin
                    last_cnt++;
                    last_idx = obuf.size();
                end
                obuf.push_back(out_data);
            end
            if (in_valid && in_ready) n_in++;
            if (out_start) begin
                n_start++;
                mon_explen = out_expected_len;
            end
            if (frame_done)   n_done++;
            if (err_underrun) n_under++;
            if (err_overrun)  n_over++;
            if (len_reject)   n_rej++;
            prv_stall = out_valid && !out_ready;
            prv_data  = out_data;
            prv_last  = out_last;
        end
    end

    task automatic clear_mon();
        obuf.delete();
        last_idx   = -1;
        last_cnt   = 0;
        n_start    = 0;
        n_done     = 0;
        n_under    = 0;
        n_over     = 0;
        n_rej      = 0;
        n_in       = 0;
        mon_explen = 16'd0;
        first_cyc  = 0;
        lastb_cyc  = 0;
    endtask

    // Advance one clock; inputs change 1-2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        #1;
    endtask

    task automatic send_desc(input logic [15:0] l);
        bit got;
        msg_valid = 1'b1;
        msg_len   = l;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            if (msg_ready) got = 1'b1;
            step();
        end
        msg_valid = 1'b0;
        check("desc_hs", 32'(got), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last);
        bit got;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            if (in_ready) begin
                got = 1'b1;
                check("busy_msg_ready", 32'(msg_ready), 32'd0);
            end
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("in_hs", 32'(got), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit got;
        logic [7:0] eb;
        string tag;
        tag = $sformatf("v%0d", idx);
        clear_mon();
        bp        = v.bp;
        chk_inrdy = v.bp;
        send_desc(v.len);
        for (int i = 0; i < v.nin; i++)
            send_byte(v.din[31-8*i -: 8], (i == v.nin - 1));
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            step();
            if (msg_ready) got = 1'b1;
        end
        check({tag, "_idle"}, 32'(got), 32'd1);
        step();
        step();
        bp        = 1'b0;
        chk_inrdy = 1'b0;

        check({tag, "_nout"}, 32'(obuf.size()), 32'(v.nout));
        for (int i = 0; i < obuf.size() && i < v.nout; i++) begin
            if (i < 6) eb = v.dout[47-8*i -: 8];
            else       eb = 8'h00;
            check($sformatf("%s_byte%0d", tag, i), 32'(obuf[i]), 32'(eb));
        end
        check({tag, "_last_cnt"}, 32'(last_cnt), (v.nout > 0) ? 32'd1 : 32'd0);
        if (v.nout > 0) begin
            check({tag, "_last_idx"}, 32'(last_idx), 32'(v.nout - 1));
            check({tag, "_explen"}, 32'(mon_explen), 32'(v.len) + 32'd2);
            if (!v.bp)
                check({tag, "_stream"}, 32'(lastb_cyc - first_cyc), 32'(v.nout - 1));
        end
        check({tag, "_start"}, 32'(n_start), (v.nout > 0) ? 32'd1 : 32'd0);
        check({tag, "_done"}, 32'(n_done), (v.nout > 0) ? 32'd1 : 32'd0);
        check({tag, "_under"}, 32'(n_under), 32'(v.under));
        check({tag, "_over"}, 32'(n_over), 32'(v.over));
        check({tag, "_rej"}, 32'(n_rej), 32'(v.rej));
        check({tag, "_nin"}, 32'(n_in), 32'(v.nin));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_msg_ready"}, 32'(msg_ready), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_start"}, 32'(out_start), 32'd0);
        check({tag, "_explen"}, 32'(out_expected_len), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_errs"}, {29'd0, err_underrun, err_overrun, len_reject}, 32'd0);
    endtask

    initial begin
        msg_valid = 1'b0;
        msg_len   = 16'd0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        //          len     nin din           nout dout              bp  un ov rj
        vecs[0] = '{16'd3,  3,  32'hA1B2C300, 5,   48'h0003A1B2C300, 1'b0, 0, 0, 0};
        vecs[1] = '{16'd4,  2,  32'h11220000, 6,   48'h000411220000, 1'b0, 1, 0, 0};
        vecs[2] = '{16'd2,  4,  32'h55667788, 4,   48'h000255660000, 1'b0, 0, 1, 0};
        vecs[3] = '{16'd0,  2,  32'hAABB0000, 0,   48'h000000000000, 1'b0, 0, 0, 1};
        vecs[4] = '{16'd65, 2,  32'hCCDD0000, 0,   48'h000000000000, 1'b0, 0, 0, 1};
        vecs[5] = '{16'd3,  3,  32'hA1B2C300, 5,   48'h0003A1B2C300, 1'b1, 0, 0, 0};
        vecs[6] = '{16'd64, 1,  32'h5A000000, 66,  48'h00405A000000, 1'b0, 1, 0, 0};
        vecs[7] = '{16'd1,  1,  32'h9F000000, 3,   48'h00019F000000, 1'b0, 0, 0, 0};

        clear_mon();

        // Reset values and msg_ready rising on the first edge after release.
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("rst");
        rst_n = 1'b1;
        #2;
        check("rel_msg_ready_before", 32'(msg_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rel_msg_ready_after", 32'(msg_ready), 32'd1);
        #1;

        for (int i = 0; i < 8; i++)
            run_vec(vecs[i], i);

        // Reset in the middle of a len=5 frame after two payload bytes.
        clear_mon();
        send_desc(16'd5);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        check("midrst_no_done", 32'(n_done), 32'd0);
        check("midrst_no_last", 32'(last_cnt), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("midrst_msg_ready_before", 32'(msg_ready), 32'd0);
        @(posedge clk);
        #1;
        check("midrst_msg_ready_after", 32'(msg_ready), 32'd1);
        #1;
        run_vec(vecs[7], 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/itch_frame_tx.md
# itch_frame_tx

Transmit-side ITCH framer. Accepts a message descriptor (payload length) plus a payload byte stream and emits a length-prefixed frame: 2-byte big-endian length header followed by exactly `msg_len` payload bytes. It enforces declared length on the producer side: short payloads are zero-padded, excess bytes are dropped, and illegal lengths are rejected. A companion `out_start`/`out_expected_len` pair lets a downstream length checker track each frame.

## Interface
- `MAX_LEN`, 64: largest legal payload length in bytes; must be ≤ 65533.

- `clk`  in  1  single clock, all logic rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `msg_valid`  in  1  descriptor valid.
- `msg_len`  in  16  declared payload length, sampled on descriptor handshake.
- `msg_ready`  out  1  descriptor accepted when `msg_valid && msg_ready`.
- `in_data`  in  8  payload byte.
- `in_valid`  in  1  payload byte valid.
- `in_last`  in  1  marks final producer byte of the message.
- `in_ready`  out  1  payload byte consumed when `in_valid && in_ready`.
- `out_data`  out  8  frame byte, registered.
- `out_valid`  out  1  frame byte valid, registered.
- `out_last`  out  1  final byte of frame, qualified by `out_valid`.
- `out_ready`  in  1  downstream accepts `out_data` when `out_valid && out_ready`.
- `out_start`  out  1  one-cycle pulse at frame start.
- `out_expected_len`  out  16  total frame bytes (`msg_len + 2`), valid from `out_start` until next `out_start`.
- `frame_done`  out  1  pulse on handshake of the `out_last` byte.
- `err_underrun`  out  1  pulse: `in_last` arrived before `msg_len` bytes.
- `err_overrun`  out  1  pulse: more than `msg_len` bytes offered.
- `len_reject`  out  1  pulse: `msg_len == 0` or `msg_len > MAX_LEN`.

## Operation
- States: IDLE, HDR_HI, HDR_LO, PAYLOAD, PAD, DRAIN.
- IDLE: `msg_ready = 1`, `in_ready = 0`. On descriptor handshake, latch `len`, clear 16-bit `count`.
  - Legal len → HDR_HI, pulse `out_start`, `out_expected_len = len + 2`.
  - Illegal len → pulse `len_reject`, go to DRAIN. Nothing is emitted.
- HDR_HI: load output register with `len[15:8]`. Advance to HDR_LO on its handshake.
- HDR_LO: load output register with `len[7:0]`. Advance to PAYLOAD on its handshake.
- PAYLOAD: `in_ready = !out_valid || out_ready`. Each consumed byte is loaded into the output register and increments `count`. Cases on the consumed byte:
  - `count+1 == len && in_last` → byte carries `out_last`, then IDLE.
  - `count+1 == len && !in_last` → byte carries `out_last`, pulse `err_overrun`, go to DRAIN.
  - `count+1 < len && in_last` → pulse `err_underrun`, go to PAD.
- PAD: emit 0x00 bytes under the same output handshake, incrementing `count`. The byte at `count+1 == len` carries `out_last`, then IDLE.
- DRAIN: `in_ready = 1`, `out_valid` falls after the pending byte handshakes. Discard bytes until the `in_last` handshake, then IDLE. DRAIN may overlap the final output handshake.
- `msg_ready` is 1 only in IDLE with no pending output byte.

## Timing
- Reset values: `msg_ready`, `in_ready`, `out_valid`, `out_last`, `out_start`, `frame_done`, all error pulses = 0. `out_data` = 0x00, `out_expected_len` = 0, state = IDLE.
- `msg_ready` is registered and rises on the first clock edge after `rst_n` release.
- Descriptor handshake at edge N:
  - `out_start` high and `out_valid` high with the header MSB in cycle N+1.
  - With `out_ready` held high and payload always valid, the frame streams one byte per cycle; `len + 2` output cycles total.
- Output-register rule: `out_data`, `out_valid` and `out_last` are stable while `out_valid && !out_ready`.
- Pulse timing: `frame_done` is asserted in the cycle after the `out_last` handshake. Error pulses are asserted in the cycle after the triggering input handshake.
- `count` never exceeds `len`; no wrap is possible given `MAX_LEN ≤ 65533`.
- Reset mid-frame: everything clears immediately. The partial frame is abandoned with no `out_last` and no `frame_done`.
- Back-to-back messages: the next descriptor may be accepted in the cycle after the prior `out_last` handshake, if not in DRAIN.

## Test plan
- Normal frame: len=3, payload 0xA1 0xB2 0xC3 with `in_last` on 0xC3, `out_ready` = 1 → output 0x00 0x03 0xA1 0xB2 0xC3. `out_last` on 0xC3; one `out_start` with `out_expected_len` = 5; one `frame_done`; no errors.
- Underrun: len=4, payload 0x11 0x22 with `in_last` on 0x22 → output 0x00 0x04 0x11 0x22 0x00 0x00. `err_underrun` pulses once; `out_last` on the second pad byte.
- Overrun: len=2, payload 0x55 0x66 0x77 0x88 with `in_last` on 0x88 → output 0x00 0x02 0x55 0x66. `err_overrun` pulses once; 0x77 and 0x88 are consumed and dropped; `msg_ready` returns only after the 0x88 handshake.
- Reject: len=0, then len=MAX_LEN+1 = 65, each followed by a 2-byte payload → `len_reject` pulses twice; zero output bytes; both payloads drained.
- Backpressure: len=3, `out_ready` toggling 1,0,0,1,… → byte order and values identical to the normal case; `out_data` stable during stalls; `in_ready` low while the output register is full and stalled.
- Reset mid-frame: assert `rst_n` low after the 2nd payload byte of a len=5 frame → all outputs 0 immediately. After release, `msg_ready` = 1 one cycle later, and a fresh len=1 frame (0x9F) emits 0x00 0x01 0x9F correctly.
